// File: rtl/axi2per_req_sched.sv
// Request-side scheduler of the AXI-to-peripheral bridge: arbitrates single-beat AXI reads/writes
// and issues one peripheral request at a time. Define AXI2PER_SCHED_WRITE_PRIO_EN for fixed write priority.
module axi2per_req_sched #(
  parameter int PER_ADDR_WIDTH = 32,
  parameter int PER_ID_WIDTH   = 5,
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int AXI_ID_WIDTH   = 3
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        axi_slave_ar_valid_i,
  output logic                        axi_slave_ar_ready_o,
  input  logic [AXI_ADDR_WIDTH-1:0]   axi_slave_ar_addr_i,
  input  logic [AXI_ID_WIDTH-1:0]     axi_slave_ar_id_i,
  input  logic                        axi_slave_aw_valid_i,
  output logic                        axi_slave_aw_ready_o,
  input  logic [AXI_ADDR_WIDTH-1:0]   axi_slave_aw_addr_i,
  input  logic [AXI_ID_WIDTH-1:0]     axi_slave_aw_id_i,
  input  logic                        axi_slave_w_valid_i,
  output logic                        axi_slave_w_ready_o,
  input  logic [AXI_DATA_WIDTH-1:0]   axi_slave_w_data_i,
  input  logic [AXI_DATA_WIDTH/8-1:0] axi_slave_w_strb_i,
  output logic                        per_master_req_o,
  input  logic                        per_master_gnt_i,
  output logic [PER_ADDR_WIDTH-1:0]   per_master_add_o,
  output logic                        per_master_we_o,
  output logic [31:0]                 per_master_wdata_o,
  output logic [3:0]                  per_master_be_o,
  output logic [PER_ID_WIDTH-1:0]     per_master_id_o,
  output logic                        trans_req_o,
  output logic                        trans_we_o,
  output logic [AXI_ID_WIDTH-1:0]     trans_id_o,
  output logic [AXI_ADDR_WIDTH-1:0]   trans_add_o,
  input  logic                        trans_r_valid_i
);

  typedef enum logic [1:0] {IDLE, RD_REQ, WR_REQ, WAIT_RESP} state_e;

  state_e                      state_q;
  logic                        req_q;
  logic                        we_q;
  logic [AXI_ADDR_WIDTH-1:0]   addr_q;
  logic [AXI_ID_WIDTH-1:0]     id_q;
  logic [31:0]                 wdata_q;
  logic [3:0]                  be_q;
  logic                        can_grant;
  logic                        rd_elig;
  logic                        wr_elig;
  logic                        grant_rd;
  logic                        grant_wr;
  logic                        lane_hi;

  // Readies are combinational so a grant completes the AXI handshake in the same cycle.
  assign can_grant = (state_q == IDLE) && !rst_i;
  assign rd_elig   = axi_slave_ar_valid_i;
  assign wr_elig   = axi_slave_aw_valid_i && axi_slave_w_valid_i;
  assign lane_hi   = axi_slave_aw_addr_i[2];

`ifdef AXI2PER_SCHED_WRITE_PRIO_EN
  assign grant_rd = can_grant && rd_elig && !wr_elig;
`else
  logic last_wr_q;
  assign grant_rd = can_grant && rd_elig && (!wr_elig || last_wr_q);
`endif
  assign grant_wr = can_grant && wr_elig && !grant_rd;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      id_q    <= '0;
      wdata_q <= '0;
      be_q    <= '0;
`ifndef AXI2PER_SCHED_WRITE_PRIO_EN
      last_wr_q <= 1'b1;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_rd) begin
            state_q <= RD_REQ;
            req_q   <= 1'b1;
            we_q    <= 1'b1;
            addr_q  <= axi_slave_ar_addr_i;
            id_q    <= axi_slave_ar_id_i;
            wdata_q <= '0;
            be_q    <= 4'hF;
`ifndef AXI2PER_SCHED_WRITE_PRIO_EN
            last_wr_q <= 1'b0;
`endif
          end else if (grant_wr) begin
            state_q <= WR_REQ;
            req_q   <= 1'b1;
            we_q    <= 1'b0;
            addr_q  <= axi_slave_aw_addr_i;
            id_q    <= axi_slave_aw_id_i;
            wdata_q <= lane_hi ? axi_slave_w_data_i[63:32] : axi_slave_w_data_i[31:0];
            be_q    <= lane_hi ? axi_slave_w_strb_i[7:4] : axi_slave_w_strb_i[3:0];
`ifndef AXI2PER_SCHED_WRITE_PRIO_EN
            last_wr_q <= 1'b1;
`endif
          end
        end
        RD_REQ, WR_REQ: begin
          // A completion arriving together with gnt is not ours yet; it is ignored.
          if (per_master_gnt_i) begin
            state_q <= WAIT_RESP;
            req_q   <= 1'b0;
          end
        end
        WAIT_RESP: begin
          if (trans_r_valid_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign axi_slave_ar_ready_o = grant_rd;
  assign axi_slave_aw_ready_o = grant_wr;
  assign axi_slave_w_ready_o  = grant_wr;

  assign per_master_req_o   = req_q;
  assign per_master_add_o   = {addr_q[PER_ADDR_WIDTH-1:2], 2'b00};
  assign per_master_we_o    = we_q;
  assign per_master_wdata_o = wdata_q;
  assign per_master_be_o    = be_q;
  assign per_master_id_o    = '0;

  assign trans_req_o = req_q && per_master_gnt_i;
  assign trans_we_o  = we_q;
  assign trans_id_o  = id_q;
  assign trans_add_o = addr_q;

endmodule

// File: tb/tb_axi2per_req_sched.sv
// Self-checking bench for axi2per_req_sched: vector table, hand-written corner sequences,
// and randomized traffic against a transaction-level reference model.
module tb_axi2per_req_sched;

`ifdef AXI2PER_SCHED_WRITE_PRIO_EN
  localparam bit PRIO_WR = 1'b1;
`else
  localparam bit PRIO_WR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        ar_valid, ar_ready, aw_valid, aw_ready, w_valid, w_ready;
  logic [31:0] ar_addr, aw_addr;
  logic [2:0]  ar_id, aw_id;
  logic [63:0] w_data;
  logic [7:0]  w_strb;
  logic        req, gnt, we, trans_req, trans_we, r_valid;
  logic [31:0] add, wdata, trans_add;
  logic [3:0]  be;
  logic [4:0]  pid;
  logic [2:0]  trans_id;

  int n_chk  = 0;
  int n_fail = 0;

  axi2per_req_sched dut (
    .clk_i(clk), .rst_i(rst),
    .axi_slave_ar_valid_i(ar_valid), .axi_slave_ar_ready_o(ar_ready),
    .axi_slave_ar_addr_i(ar_addr), .axi_slave_ar_id_i(ar_id),
    .axi_slave_aw_valid_i(aw_valid), .axi_slave_aw_ready_o(aw_ready),
    .axi_slave_aw_addr_i(aw_addr), .axi_slave_aw_id_i(aw_id),
    .axi_slave_w_valid_i(w_valid), .axi_slave_w_ready_o(w_ready),
    .axi_slave_w_data_i(w_data), .axi_slave_w_strb_i(w_strb),
    .per_master_req_o(req), .per_master_gnt_i(gnt), .per_master_add_o(add),
    .per_master_we_o(we), .per_master_wdata_o(wdata), .per_master_be_o(be),
    .per_master_id_o(pid),
    .trans_req_o(trans_req), .trans_we_o(trans_we), .trans_id_o(trans_id),
    .trans_add_o(trans_add), .trans_r_valid_i(r_valid)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic drive(input logic a, input logic aw, input logic w, input logic g, input logic rv);
    ar_valid = a; aw_valid = aw; w_valid = w; gnt = g; r_valid = rv;
  endtask

  typedef struct {
    logic        rd;
    logic [31:0] addr;
    logic [2:0]  id;
    logic [63:0] data;
    logic [7:0]  strb;
    logic [2:0]  e_rdy;
    logic [31:0] e_add;
    logic [31:0] e_wdata;
    logic [3:0]  e_be;
  } vec_t;

  vec_t tbl[6];

  int          ph;
  logic        m_last_wr, m_rd;
  logic [31:0] m_addr, lane;
  logic [2:0]  m_id;
  logic [63:0] m_data;
  logic [7:0]  m_strb;
  logic [3:0]  e_be;
  logic        rd_e, wr_e, g_rd, g_wr, first_rd;

  initial begin
    tbl[0] = '{1'b1, 32'h1000_0004, 3'd3, 64'h0, 8'h00, 3'b100, 32'h1000_0004, 32'h0, 4'hF};
    tbl[1] = '{1'b0, 32'h2000_0004, 3'd5, 64'hAAAA_BBBB_CCCC_DDDD, 8'hF0, 3'b011, 32'h2000_0004, 32'hAAAA_BBBB, 4'hF};
    tbl[2] = '{1'b0, 32'h2000_0000, 3'd5, 64'hAAAA_BBBB_CCCC_DDDD, 8'hF0, 3'b011, 32'h2000_0000, 32'hCCCC_DDDD, 4'h0};
    tbl[3] = '{1'b1, 32'h3000_0007, 3'd1, 64'h0, 8'h00, 3'b100, 32'h3000_0004, 32'h0, 4'hF};
    tbl[4] = '{1'b0, 32'h4000_0003, 3'd7, 64'h0123_4567_89AB_CDEF, 8'h5A, 3'b011, 32'h4000_0000, 32'h89AB_CDEF, 4'hA};
    tbl[5] = '{1'b0, 32'h4000_000C, 3'd0, 64'h0123_4567_89AB_CDEF, 8'h5A, 3'b011, 32'h4000_000C, 32'h0123_4567, 4'h5};

    // Reset state, with every input pushing for activity.
    rst = 1'b1;
    ar_addr = 32'h0; aw_addr = 32'h0; ar_id = 3'd0; aw_id = 3'd0; w_data = 64'h0; w_strb = 8'h0;
    drive(1, 1, 1, 1, 1);
    smp();
    chk("rst_ctrl", {ar_ready, aw_ready, w_ready, req, trans_req}, 5'b0);
    chk("rst_bus", {add, wdata, be, we, pid}, 74'h0);
    chk("rst_trans", {trans_we, trans_id, trans_add}, 36'h0);
    tick();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0);

    // Simultaneous read and write, twice.
    for (int p = 0; p < 2; p++) begin
      first_rd = !PRIO_WR;
      tick();
      ar_addr = 32'h1000_0010 + p; ar_id = 3'd1; aw_addr = 32'h2000_0004; aw_id = 3'd2;
      w_data = 64'h1111_2222_3333_4444; w_strb = 8'hFF;
      drive(1, 1, 1, 0, 0);
      smp();
      chk($sformatf("tie%0d_first", p), {ar_ready, aw_ready, w_ready}, first_rd ? 3'b100 : 3'b011);
      tick(); drive(!first_rd, first_rd, first_rd, 1, 0); smp();
      chk($sformatf("tie%0d_first_trans", p), {trans_req, trans_we, ar_ready, aw_ready}, {1'b1, first_rd, 2'b00});
      tick(); drive(!first_rd, first_rd, first_rd, 0, 1); smp();
      chk($sformatf("tie%0d_wait", p), {ar_ready, aw_ready, w_ready}, 3'b000);
      tick(); drive(!first_rd, first_rd, first_rd, 0, 0); smp();
      chk($sformatf("tie%0d_second", p), {ar_ready, aw_ready, w_ready}, first_rd ? 3'b011 : 3'b100);
      tick(); drive(0, 0, 0, 1, 0); smp();
      chk($sformatf("tie%0d_second_trans", p), {trans_req, trans_we}, {1'b1, !first_rd});
      tick(); drive(0, 0, 0, 0, 1); smp();
    end

    // Vector table: one isolated transaction per entry.
    for (int i = 0; i < 6; i++) begin
      tick();
      ar_addr = tbl[i].addr; aw_addr = tbl[i].addr; ar_id = tbl[i].id; aw_id = tbl[i].id;
      w_data = tbl[i].data; w_strb = tbl[i].strb;
      drive(tbl[i].rd, !tbl[i].rd, !tbl[i].rd, 0, 0);
      smp();
      chk($sformatf("vec%0d_ready", i), {ar_ready, aw_ready, w_ready}, tbl[i].e_rdy);
      tick(); drive(0, 0, 0, 1, 0); smp();
      chk($sformatf("vec%0d_req", i), {req, trans_req}, 2'b11);
      chk($sformatf("vec%0d_bus", i), {add, wdata, be, we},
          {tbl[i].e_add, tbl[i].e_wdata, tbl[i].e_be, tbl[i].rd});
      chk($sformatf("vec%0d_trans", i), {trans_we, trans_id, trans_add}, {tbl[i].rd, tbl[i].id, tbl[i].addr});
      tick(); drive(0, 0, 0, 0, 1); smp();
      chk($sformatf("vec%0d_done", i), {req, trans_req}, 2'b00);
    end

    // AW without W, then W without AW, then both.
    aw_addr = 32'h6000_0000; aw_id = 3'd4; w_data = 64'h5555_6666_7777_8888; w_strb = 8'h0F;
    for (int c = 0; c < 5; c++) begin
      tick(); drive(0, 1, 0, 0, 0); smp();
      chk($sformatf("aw_only%0d", c), {aw_ready, w_ready}, 2'b00);
    end
    tick(); drive(0, 0, 1, 0, 0); smp();
    chk("w_only", {aw_ready, w_ready}, 2'b00);
    tick(); drive(0, 1, 1, 0, 0); smp();
    chk("aw_w", {aw_ready, w_ready}, 2'b11);
    tick(); drive(0, 0, 0, 1, 0); smp();
    chk("aw_w_bus", {trans_req, we, wdata, be, trans_id}, {2'b10, 32'h7777_8888, 4'hF, 3'd4});
    tick(); drive(0, 0, 0, 0, 1); smp();

    // Completion coincident with gnt is ignored; next grant waits for a real completion.
    tick(); ar_addr = 32'h7000_0000; ar_id = 3'd6; drive(1, 0, 0, 0, 0); smp();
    chk("rvg_grant", ar_ready, 1'b1);
    tick(); drive(0, 0, 0, 1, 1); smp();
    chk("rvg_trans", trans_req, 1'b1);
    tick(); drive(1, 0, 0, 0, 0); smp();
    chk("rvg_still_wait", ar_ready, 1'b0);
    tick(); drive(1, 0, 0, 0, 1); smp();
    chk("rvg_resp_cycle", ar_ready, 1'b0);
    tick(); drive(1, 0, 0, 0, 0); smp();
    chk("rvg_regrant", ar_ready, 1'b1);
    tick(); drive(0, 0, 0, 1, 0); smp();
    chk("rvg_trans2", trans_req, 1'b1);
    tick(); drive(0, 0, 0, 0, 1); smp();

    // Stalled gnt with stray completions, then reset mid-request.
    tick(); ar_addr = 32'h5000_000C; ar_id = 3'd2; drive(1, 0, 0, 0, 0); smp();
    chk("stall_grant", ar_ready, 1'b1);
    for (int c = 1; c < 6; c++) begin
      tick(); drive(0, 0, 0, 0, (c == 3)); smp();
      chk($sformatf("stall%0d", c), {req, trans_req, add}, {2'b10, 32'h5000_000C});
    end
    tick(); drive(0, 0, 0, 0, 0); rst = 1'b1; #1;
    chk("stall_rst_async", req, 1'b0);
    tick(); rst = 1'b0; ar_addr = 32'h5000_0020; ar_id = 3'd5; drive(1, 0, 0, 0, 0); smp();
    chk("post_rst_idle", ar_ready, 1'b1);
    tick(); drive(0, 0, 0, 1, 0); smp();
    chk("post_rst_trans", {trans_req, trans_add}, {1'b1, 32'h5000_0020});
    tick(); drive(0, 0, 0, 0, 1); smp();

    // Randomized traffic against the reference model, from a fresh reset.
    tick(); drive(0, 0, 0, 0, 0); rst = 1'b1;
    tick(); rst = 1'b0;
    ph = 0; m_last_wr = 1'b1; m_rd = 1'b0; m_addr = '0; m_id = '0; m_data = '0; m_strb = '0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      ar_addr = $urandom; ar_id = 3'($urandom); aw_addr = $urandom; aw_id = 3'($urandom);
      w_data = {$urandom, $urandom}; w_strb = 8'($urandom);
      drive($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0);
      smp();
      rd_e = ar_valid; wr_e = aw_valid && w_valid; g_rd = 1'b0; g_wr = 1'b0;
      if (ph == 0) begin
        if (rd_e && wr_e) begin
          if (PRIO_WR || !m_last_wr) g_wr = 1'b1;
          else g_rd = 1'b1;
        end else begin
          g_rd = rd_e;
          g_wr = wr_e;
        end
      end
      chk("rnd_ctrl", {ar_ready, aw_ready, w_ready, req, trans_req},
          {g_rd, g_wr, g_wr, ph == 1, (ph == 1) && gnt});
      if (ph == 1) begin
        lane = m_addr[2] ? m_data[63:32] : m_data[31:0];
        e_be = m_rd ? 4'hF : (m_addr[2] ? m_strb[7:4] : m_strb[3:0]);
        chk("rnd_bus", {add, wdata, be, we}, {m_addr[31:2], 2'b00, m_rd ? 32'h0 : lane, e_be, m_rd});
        if (gnt) chk("rnd_trans", {trans_we, trans_id, trans_add}, {m_rd, m_id, m_addr});
      end
      if (ph == 0 && (g_rd || g_wr)) begin
        ph = 1; m_rd = g_rd; m_last_wr = g_wr;
        m_addr = g_rd ? ar_addr : aw_addr; m_id = g_rd ? ar_id : aw_id;
        m_data = w_data; m_strb = w_strb;
      end else if (ph == 1 && gnt) begin
        ph = 2;
      end else if (ph == 2 && r_valid) begin
        ph = 0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
